// File: rtl/vga_rx_monitor.sv
// VGA receive-side timing monitor.
// Samples the sync and colour pins once, rebuilds the horizontal and vertical
// position from the sync edges, checks line and frame timing, and locks after
// two consecutive clean frames. While locked, visible pixels come out with
// their (x, y) position two pclk edges after they appeared on the pins.
module vga_rx_monitor #(
    parameter int HLINE  = 800,
    parameter int HPULSE = 96,
    parameter int HBP    = 144,
    parameter int HFP    = 784,
    parameter int VLINES = 521,
    parameter int VPULSE = 2,
    parameter int VBP    = 31,
    parameter int VFP    = 511
) (
    input  logic       pclk,
    input  logic       clr_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [1:0] blue,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] pixel,
    output logic       pixel_valid,
    output logic       locked,
    output logic       frame_done,
    output logic       line_err,
    output logic       frame_err,
    output logic       err_sticky,
    output logic [7:0] frame_count
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lock_state_t;

    localparam logic [9:0] IDXMAX = 10'd1023;
    localparam logic [9:0] HLAST  = 10'(HLINE - 1);
    localparam logic [9:0] HPW    = 10'(HPULSE);
    localparam logic [9:0] HBPW   = 10'(HBP);
    localparam logic [9:0] HFPW   = 10'(HFP);
    localparam logic [9:0] VLAST  = 10'(VLINES - 1);
    localparam logic [9:0] VPW    = 10'(VPULSE);
    localparam logic [9:0] VBPW   = 10'(VBP);
    localparam logic [9:0] VFPW   = 10'(VFP);

    lock_state_t state, state_nxt;

    logic       hs_q, vs_q, hs_prev, vs_prev;
    logic [7:0] col_q;
    logic [9:0] h_reg, v_reg;
    logic       seen_h, seen_v, frame_bad;

    logic       hfall, hrise, vfall, vrise;
    logic [9:0] h_cur, v_cur;
    logic       line_err_now, frame_err_now, good_frame, visible;

    // Edge detection, position of the current sample, and timing checks.
    // Line checks wait for the first hsync fall and frame checks for the first
    // vsync fall so that a partial line or frame after reset is never flagged.
    always_comb begin
        hfall         = hs_prev & ~hs_q;
        hrise         = ~hs_prev & hs_q;
        vfall         = vs_prev & ~vs_q;
        vrise         = ~vs_prev & vs_q;
        h_cur         = 10'd0;
        v_cur         = v_reg;
        line_err_now  = 1'b0;
        frame_err_now = 1'b0;

        if (!hfall) begin
            h_cur = (h_reg == IDXMAX) ? IDXMAX : h_reg + 10'd1;
        end

        if (vfall) begin
            v_cur = 10'd0;
        end else if (hfall) begin
            v_cur = (v_reg == IDXMAX) ? IDXMAX : v_reg + 10'd1;
        end

        if (seen_h) begin
            line_err_now = (hfall && (h_reg != HLAST)) ||
                           (hrise && (h_cur != HPW)) ||
                           ((h_cur == IDXMAX) && (h_reg != IDXMAX));
        end

        if (seen_v) begin
            frame_err_now = (vfall && (v_reg != VLAST)) ||
                            (vrise && !(hfall && (v_cur == VPW))) ||
                            ((v_cur == IDXMAX) && (v_reg != IDXMAX));
        end

        good_frame = seen_v && !frame_bad && !line_err_now && !frame_err_now;
        visible    = (state == LOCKED) &&
                     (h_cur >= HBPW) && (h_cur < HFPW) &&
                     (v_cur >= VBPW) && (v_cur < VFPW);
    end

    // Lock progression: each clean frame advances one step, a reported error
    // drops straight back to SEARCH and throws away the good-frame tally.
    always_comb begin
        state_nxt = state;
        if (line_err || frame_err) begin
            state_nxt = SEARCH;
        end else if (vfall && good_frame) begin
            case (state)
                SEARCH:  state_nxt = VERIFY;
                VERIFY:  state_nxt = LOCKED;
                default: state_nxt = LOCKED;
            endcase
        end
    end

    // Lock state register; locked is registered alongside it.
    always_ff @(posedge pclk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= SEARCH;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt == LOCKED);
        end
    end

    // Pin sampling, position tracking, error flags and pixel outputs.
    always_ff @(posedge pclk or negedge clr_n) begin
        if (!clr_n) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            col_q       <= 8'd0;
            h_reg       <= 10'd0;
            v_reg       <= 10'd0;
            seen_h      <= 1'b0;
            seen_v      <= 1'b0;
            frame_bad   <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            err_sticky  <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            pixel_valid <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            pixel       <= 8'd0;
        end else begin
            hs_q    <= hsync;
            vs_q    <= vsync;
            col_q   <= {red, green, blue};
            hs_prev <= hs_q;
            vs_prev <= vs_q;
            h_reg   <= h_cur;
            v_reg   <= v_cur;
            if (hfall) begin
                seen_h <= 1'b1;
            end
            if (vfall) begin
                seen_v <= 1'b1;
            end
            frame_bad  <= vfall ? 1'b0 : (frame_bad | line_err_now | frame_err_now);
            line_err   <= line_err_now;
            frame_err  <= frame_err_now;
            err_sticky <= err_sticky | line_err_now | frame_err_now;
            frame_done <= vfall && (state == LOCKED);
            if (vfall && (state == LOCKED)) begin
                frame_count <= frame_count + 8'd1;
            end
            pixel_valid <= visible;
            if (visible) begin
                x     <= h_cur - HBPW;
                y     <= v_cur - VBPW;
                pixel <= col_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed testbench for vga_rx_monitor using a shrunken 16x10 raster so that
// hundreds of frames fit in a short run.
module tb_vga_rx_monitor;

    localparam int HLINE  = 16;
    localparam int HPULSE = 2;
    localparam int HBP    = 4;
    localparam int HFP    = 12;
    localparam int VLINES = 10;
    localparam int VPULSE = 2;
    localparam int VBP    = 3;
    localparam int VFP    = 8;

    logic       pclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [2:0] red = 3'd0;
    logic [2:0] green = 3'd0;
    logic [1:0] blue = 2'd0;
    logic [9:0] x, y;
    logic [7:0] pixel;
    logic       pixel_valid, locked, frame_done, line_err, frame_err, err_sticky;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    int         step_no = 0;
    int         drv_row = -1;
    int         drv_h = -1;
    logic [7:0] drv_col = 8'd0;

    int line_err_cnt = 0;
    int frame_err_cnt = 0;
    int frame_done_cnt = 0;
    int valid_cnt = 0;
    int pix_bad = 0;
    int wrap_seen = 0;
    int line_err_step = -1;
    int lock_rise_step = -1;
    int lock_fall_step = -1;
    int frame_start_step = -1;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    bit first_pending = 1'b0;

    logic       prev_locked = 1'b0;
    logic [7:0] prev_fc = 8'd0;
    logic [9:0] hold_x = 10'd0;
    logic [9:0] hold_y = 10'd0;
    logic [7:0] hold_pix = 8'd0;

    vga_rx_monitor #(
        .HLINE(HLINE), .HPULSE(HPULSE), .HBP(HBP), .HFP(HFP),
        .VLINES(VLINES), .VPULSE(VPULSE), .VBP(VBP), .VFP(VFP)
    ) dut (
        .pclk(pclk), .clr_n(clr_n), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .x(x), .y(y), .pixel(pixel), .pixel_valid(pixel_valid),
        .locked(locked), .frame_done(frame_done), .line_err(line_err),
        .frame_err(frame_err), .err_sticky(err_sticky), .frame_count(frame_count)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] pattern(input int r, input int h);
        return 8'(r * 37 + h * 11 + 5);
    endfunction

    // One pclk: drive the pins, wait past the edge, then log what came out.
    // Outputs seen now belong to the sample driven one step earlier.
    task automatic step(input logic hs, input logic vs, input logic [7:0] col,
                        input int r, input int h);
        int         pr, ph;
        logic [7:0] pc;
        pr = drv_row;
        ph = drv_h;
        pc = drv_col;
        hsync = hs;
        vsync = vs;
        {red, green, blue} = col;
        drv_row = r;
        drv_h = h;
        drv_col = col;
        @(posedge pclk);
        #1;
        step_no++;
        if (line_err) begin
            line_err_cnt++;
            line_err_step = step_no;
        end
        if (frame_err) frame_err_cnt++;
        if (frame_done) begin
            frame_done_cnt++;
            if (prev_fc == 8'hFF && frame_count == 8'h00) wrap_seen++;
        end
        if (locked && !prev_locked) lock_rise_step = step_no;
        if (!locked && prev_locked) lock_fall_step = step_no;
        if (pixel_valid) begin
            valid_cnt++;
            if (x !== 10'(ph - HBP) || y !== 10'(pr - VBP) || pixel !== pc) pix_bad++;
            if (first_pending) begin
                first_x = int'(x);
                first_y = int'(y);
                first_pending = 1'b0;
            end
            last_x = int'(x);
            last_y = int'(y);
            hold_x = x;
            hold_y = y;
            hold_pix = pixel;
        end else if (x !== hold_x || y !== hold_y || pixel !== hold_pix) begin
            pix_bad++;
        end
        prev_locked = locked;
        prev_fc = frame_count;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 8'd0, -1, -1);
    endtask

    // Drives raster positions from (r0,h0) up to but excluding (r1,h1).
    task automatic drive_rows(input int r0, input int h0, input int r1, input int h1,
                              input int short_row);
        int r, h, len;
        r = r0;
        h = h0;
        while (r < r1 || (r == r1 && h < h1)) begin
            len = (r == short_row) ? HLINE - 1 : HLINE;
            if (r == 0 && h == 0) frame_start_step = step_no + 1;
            step((h < HPULSE) ? 1'b0 : 1'b1, (r < VPULSE) ? 1'b0 : 1'b1,
                 pattern(r, h), r, h);
            h++;
            if (h >= len) begin
                h = 0;
                r++;
            end
        end
    endtask

    task automatic drive_frame(input int short_row);
        drive_rows(0, 0, VLINES, 0, short_row);
    endtask

    task automatic clear_holds();
        hold_x = 10'd0;
        hold_y = 10'd0;
        hold_pix = 8'd0;
        prev_locked = 1'b0;
        prev_fc = 8'd0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) step(1'b0, 1'b0, 8'hAA, -1, -1);
        checks++;
        if ({x, y, pixel, pixel_valid, locked, frame_done, line_err, frame_err,
             err_sticky, frame_count} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got x=%0d y=%0d pix=%0h lk=%0b fc=%0d, required all 0",
                     x, y, pixel, locked, frame_count);
        end
        clr_n = 1'b1;
        idle(4);
    endtask

    task automatic test_lock();
        int le0, fe0;
        le0 = line_err_cnt;
        fe0 = frame_err_cnt;
        lock_rise_step = -1;
        drive_frame(-1);
        drive_frame(-1);
        drive_frame(-1);
        checks++;
        if (lock_rise_step !== frame_start_step + 1) begin
            errors++;
            $display("[TB] FAIL lock_timing: locked rose at step %0d, required %0d",
                     lock_rise_step, frame_start_step + 1);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL locked_level: got %0b required 1", locked);
        end
        checks++;
        if (line_err_cnt - le0 != 0 || frame_err_cnt - fe0 != 0) begin
            errors++;
            $display("[TB] FAIL clean_no_errors: line_err %0d frame_err %0d, required 0 0",
                     line_err_cnt - le0, frame_err_cnt - fe0);
        end
    endtask

    task automatic test_pixels();
        int dd0;
        dd0 = frame_done_cnt;
        valid_cnt = 0;
        first_pending = 1'b1;
        drive_frame(-1);
        checks++;
        if (valid_cnt != (HFP - HBP) * (VFP - VBP)) begin
            errors++;
            $display("[TB] FAIL valid_count: got %0d required %0d", valid_cnt, (HFP - HBP) * (VFP - VBP));
        end
        checks++;
        if (first_x != 0 || first_y != 0) begin
            errors++;
            $display("[TB] FAIL first_pixel: got x=%0d y=%0d required 0 0", first_x, first_y);
        end
        checks++;
        if (last_x != HFP - HBP - 1 || last_y != VFP - VBP - 1) begin
            errors++;
            $display("[TB] FAIL last_pixel: got x=%0d y=%0d required %0d %0d",
                     last_x, last_y, HFP - HBP - 1, VFP - VBP - 1);
        end
        checks++;
        if (pix_bad != 0) begin
            errors++;
            $display("[TB] FAIL pixel_data: %0d bad observations, required 0", pix_bad);
        end
        checks++;
        if (frame_done_cnt - dd0 != 1 || frame_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL first_frame_done: pulses %0d count %0d, required 1 1",
                     frame_done_cnt - dd0, frame_count);
        end
    endtask

    task automatic test_short_line();
        int le0, fe0;
        le0 = line_err_cnt;
        fe0 = frame_err_cnt;
        lock_fall_step = -1;
        drive_frame(5);
        checks++;
        if (line_err_cnt - le0 != 1) begin
            errors++;
            $display("[TB] FAIL short_line_err: got %0d pulses required 1", line_err_cnt - le0);
        end
        checks++;
        if (lock_fall_step != line_err_step + 1) begin
            errors++;
            $display("[TB] FAIL lock_drop: fell at step %0d required %0d", lock_fall_step, line_err_step + 1);
        end
        checks++;
        if (err_sticky !== 1'b1 || frame_err_cnt - fe0 != 0) begin
            errors++;
            $display("[TB] FAIL short_line_flags: sticky=%0b frame_err=%0d required 1 0",
                     err_sticky, frame_err_cnt - fe0);
        end
        lock_rise_step = -1;
        drive_frame(-1);
        drive_frame(-1);
        drive_frame(-1);
        checks++;
        if (lock_rise_step != frame_start_step + 1) begin
            errors++;
            $display("[TB] FAIL relock: rose at step %0d required %0d", lock_rise_step, frame_start_step + 1);
        end
    endtask

    task automatic test_frame_wrap();
        int dd0;
        dd0 = frame_done_cnt;
        wrap_seen = 0;
        repeat (256) drive_frame(-1);
        checks++;
        if (frame_done_cnt - dd0 != 256) begin
            errors++;
            $display("[TB] FAIL frame_done_count: got %0d required 256", frame_done_cnt - dd0);
        end
        checks++;
        if (wrap_seen != 1) begin
            errors++;
            $display("[TB] FAIL frame_count_wrap: got %0d wraps required 1", wrap_seen);
        end
        checks++;
        if (frame_count !== 8'd2 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_count_value: got %0d locked=%0b required 2 1", frame_count, locked);
        end
        checks++;
        if (pix_bad != 0) begin
            errors++;
            $display("[TB] FAIL pixel_data_long: %0d bad observations, required 0", pix_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        int le0, fe0;
        drive_rows(0, 0, 4, 7, -1);
        #1;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({x, y, pixel, pixel_valid, locked, frame_done, line_err, frame_err,
             err_sticky, frame_count} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got x=%0d y=%0d pix=%0h lk=%0b sticky=%0b fc=%0d, required all 0",
                     x, y, pixel, locked, err_sticky, frame_count);
        end
        clear_holds();
        idle(2);
        clr_n = 1'b1;
        le0 = line_err_cnt;
        fe0 = frame_err_cnt;
        lock_rise_step = -1;
        drive_rows(4, 7, VLINES, 0, -1);
        checks++;
        if (line_err_cnt - le0 != 0 || frame_err_cnt - fe0 != 0 || err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial_after_reset: line_err %0d frame_err %0d sticky %0b, required 0 0 0",
                     line_err_cnt - le0, frame_err_cnt - fe0, err_sticky);
        end
        drive_frame(-1);
        drive_frame(-1);
        drive_frame(-1);
        checks++;
        if (lock_rise_step != frame_start_step + 1) begin
            errors++;
            $display("[TB] FAIL relock_after_reset: rose at step %0d required %0d",
                     lock_rise_step, frame_start_step + 1);
        end
    endtask

    task automatic test_hsync_stuck();
        int le0, fe0, s0;
        clr_n = 1'b0;
        clear_holds();
        idle(2);
        clr_n = 1'b1;
        idle(3);
        le0 = line_err_cnt;
        fe0 = frame_err_cnt;
        drive_rows(3, 0, 5, 0, -1);
        s0 = step_no + 1;
        repeat (1050) step(1'b1, 1'b1, 8'd0, -1, -1);
        checks++;
        if (line_err_cnt - le0 != 1) begin
            errors++;
            $display("[TB] FAIL stuck_line_err: got %0d pulses required 1", line_err_cnt - le0);
        end
        checks++;
        if (line_err_step != s0 + 1008) begin
            errors++;
            $display("[TB] FAIL stuck_err_timing: at step %0d required %0d", line_err_step, s0 + 1008);
        end
        checks++;
        if (locked !== 1'b0 || err_sticky !== 1'b1 || frame_err_cnt - fe0 != 0) begin
            errors++;
            $display("[TB] FAIL stuck_flags: locked=%0b sticky=%0b frame_err=%0d required 0 1 0",
                     locked, err_sticky, frame_err_cnt - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_frame_wrap();
        test_reset_mid_frame();
        test_hsync_stuck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameters (name, default, meaning): HLINE 800 pclk per line; HPULSE 96 hsync low width; HBP 144 first visible column; HFP 784 first column after visible; VLINES 521 lines per frame; VPULSE 2 vsync low width in lines; VBP 31 first visible line; VFP 511 first line after visible.
REQ-002 SHALL have ports (name, direction, width, meaning): pclk in 1 pixel clock, rising edge.
REQ-003 clr_n in 1 reset, asynchronous, active-low.
REQ-004 hsync in 1 horizontal sync, active-low; vsync in 1 vertical sync, active-low.
REQ-005 red in 3, green in 3, blue in 2: pixel colour from the VGA generator.
REQ-006 x out 10 visible column; y out 10 visible row; pixel out 8 {red,green,blue}; pixel_valid out 1.
REQ-007 locked out 1 timing lock; frame_done out 1 one-cycle pulse per frame; line_err out 1 one-cycle pulse; frame_err out 1 one-cycle pulse; err_sticky out 1; frame_count out 8.

Function
REQ-008 SHALL register hsync, vsync, and colour once on pclk; edges SHALL be detected between consecutive registered samples; all outputs SHALL be registered.
REQ-009 Horizontal index h: 0 on the sample where hsync first reads low; +1 per sample; saturates at 1023.
REQ-010 Line index v: 0 on the sample where vsync first reads low; +1 on each other hsync falling edge; saturates at 1023; a simultaneous vsync fall and hsync fall gives v=0.
REQ-011 line_err SHALL pulse when any of these occurs: hsync falls with h of the previous sample != HLINE-1, once the first hsync fall since reset has been seen; hsync rises at h != HPULSE; h reaches 1023.
REQ-012 frame_err SHALL pulse when any of these occurs: vsync falls with the previous frame line count != VLINES, once the first vsync fall since reset has been seen; vsync rises on a sample other than the hsync fall starting line VPULSE; v reaches 1023.
REQ-013 A good frame is the span between consecutive vsync falls with no line_err or frame_err.
REQ-014 Lock FSM states: SEARCH, then one good frame moves to VERIFY, a second consecutive good frame moves to LOCKED; locked=1 only in LOCKED.
REQ-015 Any line_err or frame_err SHALL move the FSM to SEARCH on the next edge, clear locked, and clear the good-frame tally.
REQ-016 A vsync fall coincident with an error SHALL count as a bad frame.
REQ-017 pixel_valid=1 iff locked, HBP<=h<HFP, and VBP<=v<VFP.
REQ-018 When pixel_valid=1: x=h-HBP, y=v-VBP, pixel=the colour sampled with that h.
REQ-019 When pixel_valid=0, x, y, and pixel SHALL hold their last values.
REQ-020 Pin-to-output latency SHALL be exactly 2 pclk edges for pixel, x, y, and pixel_valid.
REQ-021 frame_done SHALL pulse for one cycle on each vsync fall while locked.
REQ-022 frame_count SHALL increment on each frame_done, wrapping 255 to 0.
REQ-023 err_sticky SHALL set on any line_err or frame_err and clear only on reset.

Reset
REQ-024 While clr_n=0, all outputs SHALL be 0: x, y, pixel, pixel_valid, locked, frame_done, line_err, frame_err, err_sticky, frame_count.
REQ-025 Reset SHALL force the FSM to SEARCH and clear h, v, the seen flags, and the sync samples.
REQ-026 Assertion of reset SHALL take effect without a clock edge; release is synchronous to the next pclk edge.
REQ-027 Reset mid-frame SHALL suppress errors until the first hsync fall (line checks) and the first vsync fall (frame checks) after release.

Verification
REQ-028 Clean 800x521 stream with constant colour 8'hFF -> locked rises 1 cycle after the third vsync fall; no errors.
REQ-029 Same stream, continued after lock -> first pixel_valid has x=0, y=0, pixel=8'hFF; last has x=639, y=479; exactly 307200 valid cycles per frame.
REQ-030 Inject one 799-cycle line mid-frame while locked -> line_err pulses once, locked falls next cycle, err_sticky=1, relock after two further good frames.
REQ-031 Hold hsync high -> line_err pulses when h reaches 1023; locked stays 0.
REQ-032 Pulse clr_n low mid-frame while locked -> all outputs 0 immediately; after release no line_err on the partial line; locked returns after 2 good frames.
REQ-033 Run 256 locked frames -> frame_count wraps from 8'hFF to 8'h00 with frame_done pulse.
